// File: rtl/gan_batch_sequencer_if.sv
// Bundle of the noise-load, GAN-handshake, result-stream and status signals around gan_batch_sequencer.
// The master modport is the sequencer side; the slave modport is its environment (loader, GAN, consumer).
interface gan_batch_sequencer_if;
    logic                ld_we;
    logic [7:0]          ld_addr;
    logic signed [15:0]  ld_data;
    logic                batch_start;

    logic                gan_start;
    logic signed [15:0]  gan_noise_0;
    logic signed [15:0]  gan_noise_1;
    logic                gan_done;
    logic [143:0]        gan_image;
    logic signed [15:0]  gan_prob;

    logic                res_valid;
    logic                res_ready;
    logic [7:0]          res_index;
    logic [143:0]        res_image;
    logic signed [15:0]  res_prob;
    logic                res_real;

    logic                busy;
    logic                batch_done;
    logic [7:0]          real_count;
    logic                timeout_err;

    modport master (
        input  ld_we, ld_addr, ld_data, batch_start,
        input  gan_done, gan_image, gan_prob, res_ready,
        output gan_start, gan_noise_0, gan_noise_1,
        output res_valid, res_index, res_image, res_prob, res_real,
        output busy, batch_done, real_count, timeout_err
    );

    modport slave (
        output ld_we, ld_addr, ld_data, batch_start,
        output gan_done, gan_image, gan_prob, res_ready,
        input  gan_start, gan_noise_0, gan_noise_1,
        input  res_valid, res_index, res_image, res_prob, res_real,
        input  busy, batch_done, real_count, timeout_err
    );
endinterface

// File: rtl/gan_batch_sequencer.sv
// Replays a preloaded batch of Q1.15 noise pairs through the GAN, one sample per start/done exchange,
// and streams each captured image/probability out on a valid/ready port while counting REAL results.
module gan_batch_sequencer #(
    parameter int                 NUM_SAMPLES    = 10,
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter logic signed [15:0] THRESH         = 16'sh4000
) (
    input  logic                  clk,
    input  logic                  rst,
    gan_batch_sequencer_if.master bus
);

    localparam int              DEPTH      = 2 * NUM_SAMPLES;
    localparam int              AW         = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0]      DEPTH_W    = 9'(DEPTH);
    localparam logic [7:0]      LAST_IDX   = 8'(NUM_SAMPLES - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FIN} state_t;

    state_t             state;
    state_t             next_state;
    logic [7:0]         idx;
    logic [7:0]         next_idx;
    logic [TW-1:0]      timer;
    logic               done_hit;
    logic               timeout_hit;
    logic               handshake;
    logic               start_hit;
    logic [8:0]         rd_base;
    logic signed [15:0] ram [DEPTH];

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc);
        if (inc && (cnt != 8'hFF)) begin
            return cnt + 8'd1;
        end
        return cnt;
    endfunction

    assign start_hit   = (state == IDLE) && bus.batch_start;
    assign done_hit    = (state == WAIT) && bus.gan_done;
    assign timeout_hit = (state == WAIT) && !bus.gan_done && (timer == TIMER_LAST);
    assign handshake   = (state == EMIT) && bus.res_valid && bus.res_ready;
    assign rd_base     = {next_idx, 1'b0};
    assign bus.res_real = (bus.res_prob > THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            IDLE: begin
                if (bus.batch_start) begin
                    next_state = ISSUE;
                    next_idx   = 8'd0;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (done_hit) begin
                    next_state = EMIT;
                end else if (timeout_hit) begin
                    next_state = FIN;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        next_state = FIN;
                    end else begin
                        next_state = ISSUE;
                        next_idx   = idx + 8'd1;
                    end
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control: strobes and status are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx             <= 8'd0;
            timer           <= '0;
            bus.gan_start   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.batch_done  <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.real_count  <= 8'd0;
            bus.timeout_err <= 1'b0;
        end else begin
            idx            <= next_idx;
            bus.gan_start  <= (next_state == ISSUE);
            bus.busy       <= (next_state != IDLE);
            bus.batch_done <= (next_state == FIN);
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TW'(1);
            end
            if (done_hit) begin
                bus.res_valid <= 1'b1;
            end else if (handshake) begin
                bus.res_valid <= 1'b0;
            end
            if (start_hit) begin
                bus.real_count  <= 8'd0;
                bus.timeout_err <= 1'b0;
            end else begin
                if (handshake) begin
                    bus.real_count <= sat_inc(bus.real_count, bus.res_real);
                end
                if (timeout_hit) begin
                    bus.timeout_err <= 1'b1;
                end
            end
        end
    end

    // Datapath: noise is fetched on the way into ISSUE so it is valid alongside gan_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gan_noise_0 <= '0;
            bus.gan_noise_1 <= '0;
            bus.res_index   <= 8'd0;
            bus.res_image   <= '0;
            bus.res_prob    <= '0;
        end else begin
            if (next_state == ISSUE) begin
                bus.gan_noise_0 <= ram[AW'(rd_base)];
                bus.gan_noise_1 <= ram[AW'(rd_base + 9'd1)];
            end
            if (done_hit) begin
                bus.res_index <= idx;
                bus.res_image <= bus.gan_image;
                bus.res_prob  <= bus.gan_prob;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.ld_we && ({1'b0, bus.ld_addr} < DEPTH_W)) begin
            ram[AW'(bus.ld_addr)] <= bus.ld_data;
        end
    end

endmodule

// File: tb/tb_gan_batch_sequencer.sv
// Directed bench for gan_batch_sequencer: a fixed-latency GAN responder (prob = noise_0, pixel k = noise_1 + k)
// and a negedge monitor that logs every accepted result for the scenario tasks to inspect.
module tb_gan_batch_sequencer;
    localparam int N  = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gan_batch_sequencer_if bus();

    gan_batch_sequencer #(
        .NUM_SAMPLES(N),
        .TIMEOUT_CYCLES(TO),
        .THRESH(16'sh4000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] m_n0 [N];
    logic signed [15:0] m_n1 [N];
    bit                 resp_en = 1'b1;
    logic signed [15:0] r_n0;
    logic signed [15:0] r_n1;

    int                 n_start = 0;
    int                 n_done  = 0;
    int                 n_valid = 0;
    logic [7:0]         q_idx  [$];
    logic signed [15:0] q_prob [$];
    logic [143:0]       q_img  [$];
    logic               q_real [$];

    // GAN responder: done is seen by the DUT five edges after the edge that sampled gan_start
    initial begin
        bus.gan_done  = 1'b0;
        bus.gan_image = '0;
        bus.gan_prob  = '0;
        forever begin
            @(posedge clk);
            if (bus.gan_start && resp_en && !rst) begin
                r_n0 = bus.gan_noise_0;
                r_n1 = bus.gan_noise_1;
                repeat (4) @(posedge clk);
                #1;
                bus.gan_prob = r_n0;
                for (int k = 0; k < 9; k++) bus.gan_image[16*k +: 16] = r_n1 + 16'(k);
                bus.gan_done = 1'b1;
                @(posedge clk);
                #1;
                bus.gan_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.gan_start)  n_start <= n_start + 1;
        if (bus.batch_done) n_done  <= n_done + 1;
        if (bus.res_valid)  n_valid <= n_valid + 1;
        if (bus.res_valid && bus.res_ready) begin
            q_idx.push_back(bus.res_index);
            q_prob.push_back(bus.res_prob);
            q_img.push_back(bus.res_image);
            q_real.push_back(bus.res_real);
        end
    end

    function automatic logic [143:0] exp_img(input int i);
        logic [143:0] img;
        for (int k = 0; k < 9; k++) img[16*k +: 16] = m_n1[i] + 16'(k);
        return img;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pair(input int i, input logic signed [15:0] a, input logic signed [15:0] b);
        bus.ld_we   = 1'b1;
        bus.ld_addr = 8'(2*i);
        bus.ld_data = a;
        tick();
        bus.ld_addr = 8'(2*i + 1);
        bus.ld_data = b;
        tick();
        bus.ld_we = 1'b0;
        m_n0[i] = a;
        m_n1[i] = b;
    endtask

    task automatic load_std();
        for (int i = 0; i < N; i++)
            load_pair(i, (i % 2 == 0) ? 16'sh6000 : 16'sh2000, 16'(i*256 + 3));
    endtask

    task automatic run_batch(input int budget, output int cyc, output logic st0);
        bus.batch_start = 1'b1;
        tick();
        bus.batch_start = 1'b0;
        st0 = bus.gan_start;
        cyc = 0;
        while (bus.batch_done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.gan_start, bus.res_valid, bus.busy, bus.batch_done, bus.real_count, bus.timeout_err,
             bus.res_index, bus.res_prob, bus.res_image, bus.gan_noise_0, bus.gan_noise_1, bus.res_real} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, required all zero (busy=%b real_count=%0d)", bus.busy, bus.real_count);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", bus.busy);
        end
    endtask

    task automatic test_batch();
        int b0, s0, d0, cyc;
        logic st0;
        logic [9:0] exp_real;
        exp_real = 10'b0101010101;
        load_std();
        bus.res_ready = 1'b1;
        b0 = q_idx.size(); s0 = n_start; d0 = n_done;
        run_batch(200, cyc, st0);
        checks++;
        if (st0 !== 1'b1) begin
            errors++;
            $display("FAIL batch_first_start: gan_start=%b in cycle after batch_start, required 1", st0);
        end
        checks++;
        if (cyc !== 70) begin
            errors++;
            $display("FAIL batch_latency: batch_done after %0d cycles, required 70", cyc);
        end
        tick(); tick();
        checks++;
        if (q_idx.size() - b0 !== N) begin
            errors++;
            $display("FAIL batch_count: got %0d results required %0d", q_idx.size() - b0, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({q_idx[b0+i], q_prob[b0+i], q_img[b0+i], q_real[b0+i]} !== {8'(i), m_n0[i], exp_img(i), exp_real[i]}) begin
                errors++;
                $display("FAIL batch_result%0d: got idx=%0d prob=%h real=%b required idx=%0d prob=%h real=%b",
                         i, q_idx[b0+i], q_prob[b0+i], q_real[b0+i], i, m_n0[i], exp_real[i]);
            end
        end
        checks++;
        if ({bus.real_count, bus.timeout_err} !== {8'd5, 1'b0}) begin
            errors++;
            $display("FAIL batch_status: got real_count=%0d timeout_err=%b required 5/0", bus.real_count, bus.timeout_err);
        end
        checks++;
        if ((n_done - d0) !== 1 || (n_start - s0) !== N) begin
            errors++;
            $display("FAIL batch_pulses: got done=%0d starts=%0d required 1/%0d", n_done - d0, n_start - s0, N);
        end
    endtask

    task automatic test_backpressure();
        int b0, d0, cyc, hold_bad, s1, s2;
        bit held;
        logic [143:0] img;
        logic signed [15:0] prob;
        bus.res_ready = 1'b0;
        b0 = q_idx.size(); d0 = n_done;
        held = 1'b0; hold_bad = 0; s1 = 0; s2 = -1; cyc = 0;
        bus.batch_start = 1'b1;
        tick();
        bus.batch_start = 1'b0;
        while (bus.batch_done !== 1'b1 && cyc < 400) begin
            if (bus.res_valid === 1'b1) begin
                if (bus.res_index == 8'd3 && !held) begin
                    held = 1'b1;
                    img  = bus.res_image;
                    prob = bus.res_prob;
                    s1   = n_start;
                    repeat (20) begin
                        tick();
                        cyc++;
                        if (bus.res_valid !== 1'b1 || bus.res_image !== img || bus.res_prob !== prob) hold_bad++;
                    end
                    s2 = n_start;
                end
                bus.res_ready = 1'b1;
            end else begin
                bus.res_ready = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.res_ready = 1'b0;
        tick(); tick();
        checks++;
        if (held !== 1'b1 || hold_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: held=%b unstable_cycles=%0d required 1/0", held, hold_bad);
        end
        checks++;
        if (s2 - s1 !== 0) begin
            errors++;
            $display("FAIL bp_no_issue: got %0d gan_start pulses during stall, required 0", s2 - s1);
        end
        checks++;
        if (q_idx.size() - b0 !== N) begin
            errors++;
            $display("FAIL bp_count: got %0d results required %0d", q_idx.size() - b0, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({q_idx[b0+i], q_prob[b0+i], q_img[b0+i]} !== {8'(i), m_n0[i], exp_img(i)}) begin
                errors++;
                $display("FAIL bp_result%0d: got idx=%0d prob=%h required idx=%0d prob=%h", i, q_idx[b0+i], q_prob[b0+i], i, m_n0[i]);
            end
        end
        checks++;
        if (bus.real_count !== 8'd5 || (n_done - d0) !== 1) begin
            errors++;
            $display("FAIL bp_status: got real_count=%0d done=%0d required 5/1", bus.real_count, n_done - d0);
        end
    endtask

    task automatic test_threshold();
        int b0, cyc;
        logic st0;
        logic [9:0] exp_real;
        exp_real = 10'b0000111010;
        load_pair(0, 16'sh4000, 16'sh0010);
        load_pair(1, 16'sh4001, 16'sh0020);
        load_pair(2, 16'sh8000, 16'sh0030);
        for (int i = 3; i < 6; i++) load_pair(i, 16'sh7FFF, 16'(i));
        for (int i = 6; i < N; i++) load_pair(i, 16'shC000, 16'(i));
        bus.res_ready = 1'b1;
        b0 = q_idx.size();
        run_batch(200, cyc, st0);
        tick(); tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({q_real[b0+i], q_prob[b0+i]} !== {exp_real[i], m_n0[i]}) begin
                errors++;
                $display("FAIL thresh_real%0d: got real=%b prob=%h required real=%b prob=%h", i, q_real[b0+i], q_prob[b0+i], exp_real[i], m_n0[i]);
            end
        end
        checks++;
        if (bus.real_count !== 8'd4) begin
            errors++;
            $display("FAIL thresh_count: got %0d required 4", bus.real_count);
        end
    endtask

    task automatic test_timeout();
        int v0, d0, s0, b0, cyc;
        logic st0;
        resp_en = 1'b0;
        bus.res_ready = 1'b1;
        v0 = n_valid; d0 = n_done; s0 = n_start;
        run_batch(100, cyc, st0);
        checks++;
        if (cyc !== 17 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: batch_done after %0d cycles timeout_err=%b, required 17/1", cyc, bus.timeout_err);
        end
        tick(); tick();
        checks++;
        if ((n_done - d0) !== 1 || (n_valid - v0) !== 0 || (n_start - s0) !== 1) begin
            errors++;
            $display("FAIL timeout_pulses: got done=%0d valid=%0d starts=%0d required 1/0/1", n_done - d0, n_valid - v0, n_start - s0);
        end
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got timeout_err=%b busy=%b required 1/0", bus.timeout_err, bus.busy);
        end
        resp_en = 1'b1;
        b0 = q_idx.size();
        bus.batch_start = 1'b1;
        tick();
        bus.batch_start = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b required 0", bus.timeout_err);
        end
        cyc = 0;
        while (bus.batch_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        tick(); tick();
        checks++;
        if (q_idx.size() - b0 !== N || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: got %0d results timeout_err=%b required %0d/0", q_idx.size() - b0, bus.timeout_err, N);
        end
    endtask

    task automatic test_reset_mid();
        int b0, d0, cyc;
        logic st0;
        load_std();
        bus.res_ready = 1'b1;
        b0 = q_idx.size();
        bus.batch_start = 1'b1;
        tick();
        bus.batch_start = 1'b0;
        cyc = 0;
        while (q_idx.size() - b0 < 4 && cyc < 100) begin
            tick();
            cyc++;
        end
        tick(); tick();
        d0 = n_done;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({bus.gan_start, bus.res_valid, bus.busy, bus.batch_done, bus.real_count, bus.timeout_err,
             bus.res_index, bus.res_prob, bus.res_image, bus.gan_noise_0, bus.gan_noise_1, bus.res_real} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got nonzero (busy=%b res_index=%0d real_count=%0d) required all zero",
                     bus.busy, bus.res_index, bus.real_count);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) tick();
        checks++;
        if ((n_done - d0) !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone: got done=%0d busy=%b required 0/0", n_done - d0, bus.busy);
        end
        b0 = q_idx.size();
        run_batch(200, cyc, st0);
        tick(); tick();
        checks++;
        if (cyc !== 70 || q_idx.size() - b0 !== N) begin
            errors++;
            $display("FAIL midreset_rerun: got %0d cycles %0d results required 70/%0d", cyc, q_idx.size() - b0, N);
        end
        checks++;
        if ({q_idx[b0], q_prob[b0], bus.real_count} !== {8'd0, m_n0[0], 8'd5}) begin
            errors++;
            $display("FAIL midreset_first: got idx=%0d prob=%h real_count=%0d required 0/%h/5", q_idx[b0], q_prob[b0], bus.real_count, m_n0[0]);
        end
    endtask

    task automatic test_busy_writes();
        int b0, d0, s0, cyc;
        logic st0;
        load_std();
        bus.ld_we   = 1'b1;
        bus.ld_addr = 8'd33;
        bus.ld_data = 16'sh1234;
        tick();
        bus.ld_addr = 8'd32;
        bus.ld_data = 16'sh5555;
        tick();
        bus.ld_addr = 8'd20;
        tick();
        bus.ld_we = 1'b0;
        bus.res_ready = 1'b1;
        b0 = q_idx.size(); d0 = n_done; s0 = n_start;
        bus.batch_start = 1'b1;
        tick();
        bus.batch_start = 1'b0;
        repeat (3) tick();
        for (int a = 0; a < 20; a++) begin
            bus.ld_we       = 1'b1;
            bus.ld_addr     = 8'(a);
            bus.ld_data     = 16'sh7777;
            bus.batch_start = 1'b1;
            tick();
        end
        bus.ld_we = 1'b0;
        bus.batch_start = 1'b0;
        cyc = 0;
        while (bus.batch_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        tick(); tick();
        checks++;
        if (q_idx.size() - b0 !== N || (n_done - d0) !== 1 || (n_start - s0) !== N) begin
            errors++;
            $display("FAIL busy_run: got results=%0d done=%0d starts=%0d required %0d/1/%0d",
                     q_idx.size() - b0, n_done - d0, n_start - s0, N, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({q_idx[b0+i], q_prob[b0+i], q_img[b0+i]} !== {8'(i), m_n0[i], exp_img(i)}) begin
                errors++;
                $display("FAIL busy_result%0d: got idx=%0d prob=%h required idx=%0d prob=%h", i, q_idx[b0+i], q_prob[b0+i], i, m_n0[i]);
            end
        end
        b0 = q_idx.size();
        run_batch(200, cyc, st0);
        tick(); tick();
        checks++;
        if (cyc !== 70 || q_idx.size() - b0 !== N || bus.real_count !== 8'd5) begin
            errors++;
            $display("FAIL ram_rerun: got %0d cycles %0d results real_count=%0d required 70/%0d/5", cyc, q_idx.size() - b0, bus.real_count, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({q_prob[b0+i], q_img[b0+i]} !== {m_n0[i], exp_img(i)}) begin
                errors++;
                $display("FAIL ram_kept%0d: got prob=%h pixel0=%h required prob=%h pixel0=%h",
                         i, q_prob[b0+i], q_img[b0+i][15:0], m_n0[i], m_n1[i]);
            end
        end
    endtask

    initial begin
        bus.ld_we       = 1'b0;
        bus.ld_addr     = 8'd0;
        bus.ld_data     = '0;
        bus.batch_start = 1'b0;
        bus.res_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_batch();
        test_backpressure();
        test_threshold();
        test_timeout();
        test_reset_mid();
        test_busy_writes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gan_batch_sequencer.md
# gan_batch_sequencer

Hardware initiator for `simple_gan_top`. It replays a batch of preloaded Q1.15 noise pairs into the GAN one sample at a time, waits for each `done`, and captures the 3x3 image and discriminator probability. Each result is emitted on a valid/ready stream, and the block keeps a running count of samples classified REAL. It replaces bench-driven stimulus when the GAN runs standalone on FPGA.

## Interface
Parameters:
- `NUM_SAMPLES`, 10: noise pairs per batch (1..128); the noise RAM holds `2*NUM_SAMPLES` words.
- `TIMEOUT_CYCLES`, 1024: maximum WAIT cycles per sample before abort.
- `THRESH`, 16'sh4000: Q1.15 REAL threshold (0.5).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `ld_we`  in  1  — noise RAM write strobe.
- `ld_addr`  in  8  — word address; even = `noise_0`, odd = `noise_1` of sample `addr>>1`.
- `ld_data`  in  16  — signed Q1.15 noise word.
- `batch_start`  in  1  — begin batch; sampled in IDLE only.
- `gan_start`  out  1  — one-cycle start pulse to the GAN.
- `gan_noise_0`, `gan_noise_1`  out  16  — noise for the current sample.
- `gan_done`  in  1  — GAN completion.
- `gan_image`  in  144  — pixels 0..8 packed; pixel k is at `[16k+15:16k]`.
- `gan_prob`  in  16  — signed Q1.15 discriminator output.
- `res_valid`  out  1  — result available.
- `res_ready`  in  1  — consumer accepts.
- `res_index`  out  8  — sample index of the result.
- `res_image`  out  144  — captured image.
- `res_prob`  out  16  — captured probability.
- `res_real`  out  1  — `res_prob > THRESH`, signed, strict.
- `busy`  out  1  — high in any state except IDLE.
- `batch_done`  out  1  — one-cycle pulse at batch end.
- `real_count`  out  8  — number of REAL results accepted in this batch.
- `timeout_err`  out  1  — sticky; set on timeout, cleared by the next `batch_start`.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, EMIT, FIN.
- IDLE:
  - `ld_we` writes RAM. Writes are ignored in all other states, and writes with `ld_addr >= 2*NUM_SAMPLES` are ignored.
  - `batch_start` sets `idx=0`, `real_count=0`, `timeout_err=0`, and moves to ISSUE.
- ISSUE (one cycle):
  - `gan_start=1`.
  - `gan_noise_0/1` are loaded from `RAM[2*idx]` and `RAM[2*idx+1]` and held stable until the next ISSUE.
  - `timer=0`; next state is WAIT.
- WAIT:
  - On `gan_done`, capture `gan_image` and `gan_prob` into the result registers, set `res_index=idx`, set `res_valid=1`, and go to EMIT.
  - Otherwise `timer++`. If `timer == TIMEOUT_CYCLES-1` and `gan_done` is low, set `timeout_err=1` and go to FIN.
  - `gan_done` is ignored in every state except WAIT.
- EMIT:
  - `res_valid` stays high and the result registers stay frozen until `res_ready`.
  - On handshake:
    - `res_valid=0` and `real_count += res_real`; `real_count` saturates at 255.
    - If `idx==NUM_SAMPLES-1`, go to FIN; otherwise `idx++` and go to ISSUE.
- FIN: `batch_done=1` for one cycle, then IDLE.
- `batch_start` outside IDLE is ignored.
- `res_real` is combinational from the captured `res_prob` (signed compare). For example, `16'h4000` gives 0 and `16'h4001` gives 1.

## Timing
- Reset values:
  - All outputs are 0, including `gan_noise_*`, `res_*`, `real_count`, and `timeout_err`.
  - State is IDLE and `idx=0`.
  - RAM contents are not reset.
- Reset mid-batch: the block returns to IDLE asynchronously, `gan_start` and `res_valid` drop immediately, and no `batch_done` pulse is produced.
- All outputs except `res_real` are registered.
- Cycle-level sequence:
  - `batch_start` sampled at edge t: `gan_start` is high during cycle t+1 and WAIT is entered at t+2.
  - `gan_done` sampled at edge w: `res_valid` is high from cycle w+1.
  - Handshake at edge h: the next `gan_start` is high in cycle h+1, or `batch_done` is high in cycle h+1 if that was the last sample.
- Per-sample overhead beyond GAN latency is 2 cycles with `res_ready` held high.
- A `gan_done` arriving in the first WAIT cycle is accepted.
- If `gan_done` and timeout coincide, `gan_done` wins.

## Test plan
- Bench responder: fixed latency 5, `prob = noise_0`, `pixel k = noise_1 + k`.
- Scenario 1: load 10 pairs, with `noise_0` alternating `16'h6000`/`16'h2000`; `res_ready=1`; pulse `batch_start`.
  - 10 results with `res_index` 0..9 in order.
  - `real_count=5`; `batch_done` pulses once; `timeout_err=0`.
- Scenario 2: backpressure — hold `res_ready=0` for 20 cycles on sample 3.
  - `res_valid` stays high and `res_image`/`res_prob` are unchanged.
  - No `gan_start` is issued until the handshake; counts are unaffected.
- Scenario 3: threshold boundary — `prob` of `16'h4000`, `16'h4001`, `16'h8000` (-1.0).
  - `res_real` = 0, 1, 0 respectively.
- Scenario 4: timeout — with `TIMEOUT_CYCLES=16`, the responder never asserts `done`.
  - `timeout_err=1` after 16 WAIT cycles; `batch_done` pulses; no `res_valid`.
  - A new `batch_start` clears `timeout_err`.
- Scenario 5: assert `rst` during sample 4's WAIT.
  - All outputs are 0 in the same cycle; `busy=0`.
  - A subsequent batch restarts at `res_index` 0.
- Scenario 6: `ld_we` and `batch_start` while `busy`.
  - RAM is unchanged (verified in the next batch) and the running batch is unaffected.
